dc_pio_responder: RTL
=====================

// Module: dc_pio_responder
// PURPOSE
//  Synthesizable responder for the device-controller PIO bus (CSF/RDF/WRF, 2-bit ADDR, 16-bit bidir DATA).
//  Emulates the DC side of the command/data port protocol: chip ID, scratch, interrupt register, one OUT and one IN endpoint.
//  Sits in the loopback/bring-up bench and FPGA self-test builds in place of the external controller, opposite the dc_if initiator.
//  Raises INT1 when OUT data is pending.
// PARAMETERS
//  CHIP_ID     16'h3630  value returned by cmd 0xB5
//  FIFO_DEPTH  64        OUT-endpoint FIFO depth in 16-bit words (power of 2)
// PORTS
//  I_CLK        in   1   clock, 50 MHz
//  I_RSTF       in   1   asynchronous reset, active low
//  I_DC_RSTF    in   1   DC reset from initiator, active low, sync to I_CLK
//  I_DC_ADDR    in   2   [1]=1 selects DC, [0]=1 command port / 0 data port
//  I_DC_CSF     in   1   chip select, active low
//  I_DC_RDF     in   1   read strobe, active low
//  I_DC_WRF     in   1   write strobe, active low
//  IO_DC_DATA   inout 16 data bus; driven only during a DC data-port read
//  O_DC_INT1    out  1   interrupt, active high, = |int_reg
//  I_RX_VALID   in   1   push one word into OUT FIFO (host->device traffic)
//  I_RX_DATA    in   16  OUT word
//  O_RX_READY   out  1   OUT FIFO not full
//  O_TX_VALID   out  1   one-cycle pulse per IN word written by initiator
//  O_TX_DATA    out  16  IN word, valid with O_TX_VALID
// BEHAVIOUR
//  Reset (I_RSTF low, async; or I_DC_RSTF low, sync): cmd=0x00, word_idx=0, scratch=0, int_reg=0, FIFO empty,
//   O_DC_INT1=0, O_TX_VALID=0, O_TX_DATA=0, O_RX_READY=1, IO_DC_DATA=Z. Bus strobes ignored while in reset.
//  Strobes: CSF/RDF/WRF pass 2-FF synchronizers; access = CSF low & ADDR[1]=1. Event = sync'd rising edge of RDF or WRF.
//  Write data: IO_DC_DATA registered every clock while raw WRF low; value at WRF rising edge is used.
//  Read drive: IO_DC_DATA = rd_word when raw CSF=0 & RDF=0 & ADDR=2'b10 (combinational OE), else Z.
//  rd_word registered; updated within 3 clocks of any event. Initiator guarantees >=4 clocks between strobes.
//  Command write (ADDR=11, WR): cmd<=DATA[7:0], word_idx<=0. Command-port reads return 0 and have no effect.
//  Data-port access: word_idx+1 on each event (saturates at 16'hFFFF); effect by cmd:
//   0xB5 rd: CHIP_ID every word.  0xB2 wr: scratch<=data.  0xB3 rd: scratch.
//   0xC0 rd: word0=int_reg[15:0], word1=int_reg[31:16]; rising edge of word1 read clears int_reg
//     (bit set by a same-cycle event wins over the clear).
//   0x10 rd (OUT buf): word0 = byte count = 2*fifo_count (snapshot at cmd write); words>=1 pop FIFO head;
//     read when empty returns 0x0000, no pop, no underflow.
//   0x01 wr (IN buf): word0 = byte length, stored not forwarded; words>=1 -> O_TX_DATA=data, O_TX_VALID=1 for 1 clock.
//   Any other cmd: reads return 0x0000, writes discarded.
//  int_reg: bit0 set when a word is pushed into FIFO; bit1 set on I_RX_VALID while full (word dropped); others 0.
//  FIFO: I_RX_VALID & O_RX_READY pushes; simultaneous push+pop legal, count unchanged; pointers wrap mod FIFO_DEPTH.
//  O_RX_READY = count < FIFO_DEPTH, registered (deasserts the clock after the push that fills FIFO).
//  Reset mid-access: drops access; rd_word=0, OE follows raw strobes, so a pending read returns 0x0000.
// TESTING
//  Write cmd 0xB5, read data port -> 0x3630; read again -> 0x3630.
//  cmd 0xB2 write 0xA55A; cmd 0xB3 read -> 0xA55A; pulse I_DC_RSTF; cmd 0xB3 read -> 0x0000.
//  Push 3 words 0x1111,0x2222,0x3333 -> INT1=1; cmd 0x10 reads 0x0006,0x1111,0x2222,0x3333,0x0000.
//  cmd 0xC0 reads 0x0001,0x0000 -> INT1=0 after second read; next 0xC0 read -> 0x0000.
//  Push 65 words into empty FIFO -> O_RX_READY=0 after 64th, int_reg=0x0003, 0x10 byte count 0x0080.
//  cmd 0x01 write 0x0004,0xBEEF,0xCAFE -> two O_TX_VALID pulses with 0xBEEF then 0xCAFE, none for length word.

Source files
------------

// File: rtl/dc_pio_responder.sv
// Device-controller side of the PIO command/data port: chip ID, scratch, interrupt
// register, one OUT endpoint backed by a FIFO and one IN endpoint streamed out as pulses.
module dc_pio_responder #(
    parameter logic [15:0] CHIP_ID    = 16'h3630,
    parameter int          FIFO_DEPTH = 64
) (
    input  logic        I_CLK,
    input  logic        I_RSTF,
    input  logic        I_DC_RSTF,
    input  logic [1:0]  I_DC_ADDR,
    input  logic        I_DC_CSF,
    input  logic        I_DC_RDF,
    input  logic        I_DC_WRF,
    inout  wire  [15:0] IO_DC_DATA,
    output logic        O_DC_INT1,
    input  logic        I_RX_VALID,
    input  logic [15:0] I_RX_DATA,
    output logic        O_RX_READY,
    output logic        O_TX_VALID,
    output logic [15:0] O_TX_DATA
);
    localparam int AW = $clog2(FIFO_DEPTH);

    // Strobes and address pass through matching stages; the extra *_d stage lines
    // csf/addr up with the last "strobe low" sample seen by the edge detector.
    logic [1:0]  csf_s, rdf_s, wrf_s;
    logic [1:0]  addr_s0, addr_s1, addr_d;
    logic        csf_d, rdf_d, wrf_d;
    logic [15:0] wr_data;

    always_ff @(posedge I_CLK or negedge I_RSTF) begin
        if (!I_RSTF) begin
            csf_s   <= 2'b11;
            rdf_s   <= 2'b11;
            wrf_s   <= 2'b11;
            csf_d   <= 1'b1;
            rdf_d   <= 1'b1;
            wrf_d   <= 1'b1;
            addr_s0 <= 2'b00;
            addr_s1 <= 2'b00;
            addr_d  <= 2'b00;
        end else if (!I_DC_RSTF) begin
            csf_s   <= 2'b11;
            rdf_s   <= 2'b11;
            wrf_s   <= 2'b11;
            csf_d   <= 1'b1;
            rdf_d   <= 1'b1;
            wrf_d   <= 1'b1;
            addr_s0 <= 2'b00;
            addr_s1 <= 2'b00;
            addr_d  <= 2'b00;
        end else begin
            csf_s   <= {csf_s[0], I_DC_CSF};
            rdf_s   <= {rdf_s[0], I_DC_RDF};
            wrf_s   <= {wrf_s[0], I_DC_WRF};
            csf_d   <= csf_s[1];
            rdf_d   <= rdf_s[1];
            wrf_d   <= wrf_s[1];
            addr_s0 <= I_DC_ADDR;
            addr_s1 <= addr_s0;
            addr_d  <= addr_s1;
        end
    end

    // The last value seen while WRF is low is the one the write event consumes.
    always_ff @(posedge I_CLK or negedge I_RSTF) begin
        if (!I_RSTF)
            wr_data <= 16'h0000;
        else if (!I_DC_WRF)
            wr_data <= IO_DC_DATA;
    end

    logic rd_evt, wr_evt, acc, cmd_wr, dat_rd, dat_wr;
    assign rd_evt = rdf_s[1] & ~rdf_d;
    assign wr_evt = wrf_s[1] & ~wrf_d;
    assign acc    = ~csf_d & addr_d[1];
    assign cmd_wr = acc &  addr_d[0] & wr_evt;
    assign dat_rd = acc & ~addr_d[0] & rd_evt;
    assign dat_wr = acc & ~addr_d[0] & wr_evt;

    logic [7:0]  cmd;
    logic [15:0] word_idx, scratch, snap, rd_word, rd_nxt;
    logic [31:0] int_reg;

    // OUT FIFO. Valid/ready: a word transfers on every clock where I_RX_VALID and
    // O_RX_READY are both high; I_RX_VALID while not ready drops the word and sets int_reg[1].
    logic [15:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count, count_nxt;
    logic          rx_ready, push, overflow, pop;

    assign push     = I_RX_VALID & rx_ready;
    assign overflow = I_RX_VALID & ~rx_ready;
    assign pop      = dat_rd & (cmd == 8'h10) & (word_idx != 16'h0000) & (count != '0);

    always_comb begin
        count_nxt = count;
        if (push && !pop)
            count_nxt = count + 1'b1;
        else if (pop && !push)
            count_nxt = count - 1'b1;
    end

    always_ff @(posedge I_CLK) begin
        if (push)
            mem[wr_ptr] <= I_RX_DATA;
    end

    always_ff @(posedge I_CLK or negedge I_RSTF) begin
        if (!I_RSTF) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            rx_ready <= 1'b1;
        end else if (!I_DC_RSTF) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            rx_ready <= 1'b1;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            count    <= count_nxt;
            rx_ready <= ~count_nxt[AW];
        end
    end

    // Word the next data-port read will return, given current command state.
    always_comb begin
        rd_nxt = 16'h0000;
        case (cmd)
            8'hB5: rd_nxt = CHIP_ID;
            8'hB3: rd_nxt = scratch;
            8'hC0: begin
                if (word_idx == 16'd0)
                    rd_nxt = int_reg[15:0];
                else if (word_idx == 16'd1)
                    rd_nxt = int_reg[31:16];
            end
            8'h10: begin
                if (word_idx == 16'd0)
                    rd_nxt = snap;
                else if (count != '0)
                    rd_nxt = mem[rd_ptr];
            end
            default: rd_nxt = 16'h0000;
        endcase
    end

    logic int_clr;
    assign int_clr = dat_rd & (cmd == 8'hC0) & (word_idx == 16'd1);

    always_ff @(posedge I_CLK or negedge I_RSTF) begin
        if (!I_RSTF) begin
            cmd        <= 8'h00;
            word_idx   <= 16'h0000;
            scratch    <= 16'h0000;
            snap       <= 16'h0000;
            int_reg    <= 32'h0;
            rd_word    <= 16'h0000;
            O_TX_VALID <= 1'b0;
            O_TX_DATA  <= 16'h0000;
        end else if (!I_DC_RSTF) begin
            cmd        <= 8'h00;
            word_idx   <= 16'h0000;
            scratch    <= 16'h0000;
            snap       <= 16'h0000;
            int_reg    <= 32'h0;
            rd_word    <= 16'h0000;
            O_TX_VALID <= 1'b0;
            O_TX_DATA  <= 16'h0000;
        end else begin
            O_TX_VALID <= 1'b0;
            int_reg    <= (int_clr ? 32'h0 : int_reg) | {30'h0, overflow, push};
            // Held while a read strobe is low so the bus value cannot change mid-read.
            if (I_DC_RDF)
                rd_word <= rd_nxt;
            if (cmd_wr) begin
                cmd      <= wr_data[7:0];
                word_idx <= 16'h0000;
                snap     <= 16'({count, 1'b0});
            end
            if ((dat_rd || dat_wr) && word_idx != 16'hFFFF)
                word_idx <= word_idx + 16'd1;
            if (dat_wr && cmd == 8'hB2)
                scratch <= wr_data;
            if (dat_wr && cmd == 8'h01 && word_idx != 16'h0000) begin
                O_TX_VALID <= 1'b1;
                O_TX_DATA  <= wr_data;
            end
        end
    end

    assign IO_DC_DATA = (!I_DC_CSF && !I_DC_RDF && I_DC_ADDR == 2'b10) ? rd_word : 16'hzzzz;
    assign O_DC_INT1  = |int_reg;
    assign O_RX_READY = rx_ready;

endmodule
